// File: rtl/assert_win_change_stim_pkg.sv
// Shared types and constants for the window-change stimulus generator and its LFSR.
package win_change_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        OPEN  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int GAP_CYCLES = 2;

    // Right-shift Galois masks giving a maximal-length sequence for each width.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/assert_win_change_stim_if.sv
// Config and stimulus bundle between the generator (master) and the checker/bench side (slave).
interface assert_win_change_stim_if #(
    parameter int width     = 8,
    parameter int cnt_width = 8
);
    logic                 enable;
    logic [cnt_width-1:0] win_len;
    logic [cnt_width-1:0] chg_offset;
    logic                 inject_err;

    logic                 start_event;
    logic                 end_event;
    logic [width-1:0]     test_expr;
    logic                 window;
    logic                 expect_fire;
    logic                 busy;
    logic [15:0]          win_count;

    modport master (
        input  enable, win_len, chg_offset, inject_err,
        output start_event, end_event, test_expr, window, expect_fire, busy, win_count
    );

    modport slave (
        output enable, win_len, chg_offset, inject_err,
        input  start_event, end_event, test_expr, window, expect_fire, busy, win_count
    );
endinterface

// File: rtl/assert_win_change_stim_lfsr.sv
// Galois LFSR that steps only on advance, so consecutive visible values always differ.
// Latency: next_state is combinational from state; no backpressure.
module win_change_lfsr
    import win_change_stim_pkg::*;
#(
    parameter int          width = 8,
    parameter logic [31:0] seed  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [width-1:0] state,
    output logic [width-1:0] next_state
);

    localparam logic [width-1:0] TAPS = width'(lfsr_taps(width));

    logic [width-1:0] state_q;

    assign next_state = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    assign state      = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= width'(seed);
        end else if (advance) begin
            state_q <= next_state;
        end
    end

endmodule

// File: rtl/assert_win_change_stim.sv
// Drives start/end events and a test_expr change (or its omission) through windows of length L.
// Latency: start_event one cycle after enable, L+4 cycles per window; inputs only sampled in IDLE.
module assert_win_change_stim
    import win_change_stim_pkg::*;
#(
    parameter int          width     = 8,
    parameter int          cnt_width = 8,
    parameter logic [31:0] seed      = 32'h0000_0001
) (
    input  logic                    clk,
    input  logic                    reset,
    assert_win_change_stim_if.master bus
);

    localparam int GAP_W = $clog2(GAP_CYCLES);

    state_t               state_q;
    state_t               state_d;
    logic [cnt_width-1:0] cnt_q;
    logic [cnt_width-1:0] len_q;
    logic [cnt_width-1:0] off_q;
    logic                 err_q;
    logic [GAP_W-1:0]     gap_q;
    logic [15:0]          win_count_q;

    logic [cnt_width-1:0] len_in;
    logic [cnt_width-1:0] off_in;
    logic                 last_open;
    logic                 last_gap;
    logic                 advance;
    logic [width-1:0]     lfsr_state;
    logic [width-1:0]     unused_lfsr_next;

    assign len_in    = (bus.win_len == '0) ? cnt_width'(1) : bus.win_len;
    assign off_in    = (bus.chg_offset >= len_in) ? (len_in - cnt_width'(1)) : bus.chg_offset;
    assign last_open = (cnt_q == (len_q - cnt_width'(1)));
    assign last_gap  = (gap_q == GAP_W'(GAP_CYCLES - 1));
    // The change is skipped entirely for an injected-error window.
    assign advance   = (state_q == OPEN) && (cnt_q == off_q) && !err_q;

    win_change_lfsr #(
        .width (width),
        .seed  (seed)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .advance    (advance),
        .state      (lfsr_state),
        .next_state (unused_lfsr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = START;
            START:   state_d = OPEN;
            OPEN:    if (last_open) state_d = GAP;
            GAP:     if (last_gap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            len_q       <= cnt_width'(1);
            off_q       <= '0;
            err_q       <= 1'b0;
            gap_q       <= '0;
            win_count_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        len_q <= len_in;
                        off_q <= off_in;
                        err_q <= bus.inject_err;
                    end
                end
                START: cnt_q <= '0;
                OPEN: begin
                    cnt_q <= cnt_q + cnt_width'(1);
                    gap_q <= '0;
                end
                GAP: begin
                    gap_q <= gap_q + GAP_W'(1);
                    if (last_gap) win_count_q <= win_count_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.start_event = (state_q == START);
    assign bus.end_event   = (state_q == OPEN) && last_open;
    assign bus.window      = (state_q == OPEN);
    assign bus.expect_fire = (state_q == GAP) && (gap_q == '0) && err_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.win_count   = win_count_q;
    assign bus.test_expr   = lfsr_state;

endmodule

// File: tb/tb_assert_win_change_stim.sv
// Scoreboard bench: stimulus queues timed output events, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_assert_win_change_stim;

    localparam int W  = 8;
    localparam int CW = 8;

    localparam int K_START  = 0;
    localparam int K_BUSY_R = 1;
    localparam int K_WIN_R  = 2;
    localparam int K_CHG    = 3;
    localparam int K_END    = 4;
    localparam int K_WIN_F  = 5;
    localparam int K_FIRE   = 6;
    localparam int K_BUSY_F = 7;
    localparam int K_WCNT   = 8;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] dat;
    } ev_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    ev_t         exp_q[$];
    logic [7:0]  m_lfsr = 8'h01;
    logic [15:0] m_wc   = 16'h0000;
    logic        p_busy = 1'b0;
    logic        p_win  = 1'b0;
    logic [7:0]  p_te   = 8'h01;
    logic [15:0] p_wc   = 16'h0000;

    assert_win_change_stim_if #(.width(W), .cnt_width(CW)) bus ();

    assert_win_change_stim #(
        .width     (W),
        .cnt_width (CW),
        .seed      (32'h0000_0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_START:  return "start_event";
            K_BUSY_R: return "busy_rise";
            K_WIN_R:  return "window_rise";
            K_CHG:    return "test_expr_change";
            K_END:    return "end_event";
            K_WIN_F:  return "window_fall";
            K_FIRE:   return "expect_fire";
            K_BUSY_F: return "busy_fall";
            K_WCNT:   return "win_count_step";
            default:  return "unknown";
        endcase
    endfunction

    function automatic logic [7:0] galois8(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int k, input logic [15:0] d);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = k;
        e.dat  = d;
        i = exp_q.size();
        while (i > 0 && (exp_q[i-1].cyc * 16 + exp_q[i-1].kind) > (c * 16 + k)) i--;
        exp_q.insert(i, e);
    endtask

    // Expected events for a window whose enable is sampled at the end of cycle t.
    task automatic launch(input int l, input int o, input bit e, input int t);
        int le;
        int oe;
        le = (l == 0) ? 1 : l;
        oe = (o >= le) ? le - 1 : o;
        push_ev(t + 1, K_START, 16'h0);
        push_ev(t + 1, K_BUSY_R, 16'h1);
        push_ev(t + 2, K_WIN_R, 16'h1);
        if (!e) begin
            m_lfsr = galois8(m_lfsr);
            push_ev(t + 3 + oe, K_CHG, {8'h00, m_lfsr});
        end
        push_ev(t + 1 + le, K_END, 16'h1);
        push_ev(t + 2 + le, K_WIN_F, 16'h0);
        if (e) push_ev(t + 2 + le, K_FIRE, 16'h1);
        push_ev(t + 4 + le, K_BUSY_F, 16'h0);
        m_wc = m_wc + 16'd1;
        push_ev(t + 4 + le, K_WCNT, m_wc);
    endtask

    task automatic observe(input int k, input logic [15:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s at cycle %0d: got data 0x%0h, required no event", kname(k), cyc, d);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.dat != d) begin
                errors++;
                $display("FAIL %s: got %s at cycle %0d data 0x%0h, required %s at cycle %0d data 0x%0h",
                         kname(e.kind), kname(k), cyc, d, kname(e.kind), e.cyc, e.dat);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d events still pending after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " start_event"}, 32'(bus.start_event), 32'd0);
        check({tag, " end_event"},   32'(bus.end_event),   32'd0);
        check({tag, " window"},      32'(bus.window),      32'd0);
        check({tag, " busy"},        32'(bus.busy),        32'd0);
        check({tag, " expect_fire"}, 32'(bus.expect_fire), 32'd0);
        check({tag, " win_count"},   32'(bus.win_count),   32'd0);
        check({tag, " test_expr"},   32'(bus.test_expr),   32'h01);
    endtask

    task automatic run_window(input int l, input int o, input bit e);
        int t;
        t = cyc;
        bus.win_len    = CW'(l);
        bus.chg_offset = CW'(o);
        bus.inject_err = e;
        bus.enable     = 1'b1;
        launch(l, o, e, t);
        tick();
        // Mid-window input changes must not leak into the running window.
        bus.enable     = 1'b0;
        bus.win_len    = 8'd7;
        bus.chg_offset = 8'd0;
        bus.inject_err = ~e;
        drain(64);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.start_event)            observe(K_START, 16'h0);
                if (bus.busy && !p_busy)        observe(K_BUSY_R, 16'h1);
                if (bus.window && !p_win)       observe(K_WIN_R, 16'h1);
                if (bus.test_expr != p_te)      observe(K_CHG, {8'h00, bus.test_expr});
                if (bus.end_event)              observe(K_END, 16'h1);
                if (!bus.window && p_win)       observe(K_WIN_F, 16'h0);
                if (bus.expect_fire)            observe(K_FIRE, 16'h1);
                if (!bus.busy && p_busy)        observe(K_BUSY_F, 16'h0);
                if (bus.win_count != p_wc)      observe(K_WCNT, bus.win_count);
            end
            p_busy = bus.busy;
            p_win  = bus.window;
            p_te   = bus.test_expr;
            p_wc   = bus.win_count;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        bus.enable     = 1'b0;
        bus.win_len    = 8'd0;
        bus.chg_offset = 8'd0;
        bus.inject_err = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        check_reset_outputs("post-reset");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle test_expr", 32'(bus.test_expr), 32'h01);
        end

        run_window(4, 2, 1'b0);
        check("w1 test_expr", 32'(bus.test_expr), 32'hB8);
        check("w1 win_count", 32'(bus.win_count), 32'd1);

        run_window(3, 1, 1'b1);
        check("err test_expr held", 32'(bus.test_expr), 32'hB8);
        check("err win_count", 32'(bus.win_count), 32'd2);

        run_window(0, 9, 1'b0);
        check("L0 test_expr", 32'(bus.test_expr), 32'h5C);
        check("L0 win_count", 32'(bus.win_count), 32'd3);

        t0 = cyc;
        bus.win_len    = 8'd3;
        bus.chg_offset = 8'd1;
        bus.inject_err = 1'b0;
        bus.enable     = 1'b1;
        for (int k = 0; k < 300; k++) launch(3, 1, 1'b0, t0 + k * 7);
        repeat (299 * 7 + 1) tick();
        bus.enable = 1'b0;
        drain(64);
        check("b2b win_count", 32'(bus.win_count), 32'd303);

        t0 = cyc;
        bus.win_len    = 8'd2;
        bus.chg_offset = 8'd0;
        bus.inject_err = 1'b0;
        bus.enable     = 1'b1;
        m_wc = 16'hFFFF;
        launch(2, 0, 1'b0, t0);
        tick();
        bus.enable = 1'b0;
        force dut.win_count_q = 16'hFFFF;
        p_wc = 16'hFFFF;
        tick();
        release dut.win_count_q;
        drain(64);
        check("wrap win_count", 32'(bus.win_count), 32'd0);

        t0 = cyc;
        bus.win_len    = 8'd6;
        bus.chg_offset = 8'd4;
        bus.inject_err = 1'b0;
        bus.enable     = 1'b1;
        push_ev(t0 + 1, K_START, 16'h0);
        push_ev(t0 + 1, K_BUSY_R, 16'h1);
        push_ev(t0 + 2, K_WIN_R, 16'h1);
        tick();
        bus.enable = 1'b0;
        repeat (3) tick();
        check("pre-reset window", 32'(bus.window), 32'd1);
        mon_en = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_outputs("mid-window reset");
        check("pre-reset events pending", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("in-reset end_event", 32'(bus.end_event), 32'd0);
        end
        reset  = 1'b0;
        m_lfsr = 8'h01;
        m_wc   = 16'h0000;
        tick();
        mon_en = 1'b1;
        check_reset_outputs("after re-reset");
        run_window(4, 2, 1'b0);
        check("rerun test_expr", 32'(bus.test_expr), 32'hB8);
        check("rerun win_count", 32'(bus.win_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
